// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: datapath widths and the
// MEM-stage sequencer state encoding.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/ready handshake between the MEM stage and memory.
interface mem_access_ctrl_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues variable-latency memory accesses, stalls the
// upstream pipeline while one is outstanding, and registers the MEM/WB fields.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_wen,
  input  logic [REG_AW-1:0] reg_waddr,
  mem_access_ctrl_if.master bus,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_MAX - 1);

  mem_state_e       state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc;
  logic             timeout;

  assign acc = mem_read | mem_write;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state    = state;
    stall         = 1'b0;
    timeout       = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = alu_result;
    bus.mem_wdata = rdata2;
    case (state)
      IDLE: begin
        if (acc) begin
          stall      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        // Request is masked during reset so an abandoned access never leaks out.
        bus.mem_req = rst;
        bus.mem_we  = mem_write;
        if (bus.mem_ready) begin
          next_state = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      wb_data  <= '0;
      wb_wen   <= 1'b0;
      wb_waddr <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (acc) begin
          wait_cnt <= '0;
          wb_wen   <= 1'b0;
          if (mem_read && mem_write) err <= 1'b1;
        end else begin
          wb_data  <= alu_result;
          wb_wen   <= reg_wen;
          wb_waddr <= reg_waddr;
        end
      end else if (bus.mem_ready) begin
        wb_data  <= mem_to_reg ? bus.mem_rdata : alu_result;
        wb_wen   <= reg_wen;
        wb_waddr <= reg_waddr;
      end else begin
        // Stalled or aborted: the slot retires as a bubble.
        wb_wen <= 1'b0;
        if (timeout) err <= 1'b1;
        else         wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: pass-through, load, store, timeout,
// read/write conflict and reset in the middle of an access.
module tb_mem_access_ctrl;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rdata2;
  logic              mem_read, mem_write, mem_to_reg, reg_wen;
  logic [REG_AW-1:0] reg_waddr;
  logic              stall, wb_wen, err;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_waddr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .rdata2     (rdata2),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_wen    (reg_wen),
    .reg_waddr  (reg_waddr),
    .bus        (bus.master),
    .stall      (stall),
    .wb_data    (wb_data),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_wen    = 1'b0;
    reg_waddr  = '0;
    alu_result = '0;
    rdata2     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_nop();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Presents one memory instruction, holds it while stall is high, answers
  // mem_ready on ACCESS cycle ready_at (0 = never), then drives a NOP.
  task automatic do_mem(input string tag, input logic rd, input logic wr,
                        input logic m2r, input logic wen, input logic [3:0] waddr,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata, input int ready_at,
                        output int stall_cnt, output int req_cnt);
    logic s;
    logic bubble_bad;
    logic done;
    mem_read = rd; mem_write = wr; mem_to_reg = m2r;
    reg_wen = wen; reg_waddr = waddr; alu_result = addr; rdata2 = wdata;
    bus.mem_rdata = rdata;
    stall_cnt = 0; req_cnt = 0; bubble_bad = 1'b0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.mem_req) begin
        req_cnt++;
        bus.mem_ready = (req_cnt == ready_at);
        if (req_cnt == 1) begin
          check({tag, " mem_addr"},  bus.mem_addr,  addr);
          check({tag, " mem_we"},    bus.mem_we,    wr);
          if (wr) check({tag, " mem_wdata"}, bus.mem_wdata, wdata);
        end
      end
      #1;
      s = stall;
      if (s) stall_cnt++;
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (!s) begin
        done = 1'b1;
        break;
      end
      if (wb_wen) bubble_bad = 1'b1;
    end
    drive_nop();
    check({tag, " retired"}, done, 1'b1);
    check({tag, " wb_wen low in stall"}, bubble_bad, 1'b0);
  endtask

  initial begin
    int sc, rc;

    // Reset values
    do_reset();
    rst = 1'b0;
    #1;
    check("rst mem_req", bus.mem_req, 1'b0);
    check("rst stall",   stall,       1'b0);
    check("rst wb_data", wb_data,     16'h0);
    check("rst wb_wen",  wb_wen,      1'b0);
    check("rst wb_waddr", wb_waddr,   4'h0);
    check("rst err",     err,         1'b0);
    rst = 1'b1;
    step();

    // Non-memory pass-through
    alu_result = 16'h1234; reg_wen = 1'b1; reg_waddr = 4'd3;
    #1;
    check("alu stall",   stall,       1'b0);
    check("alu mem_req", bus.mem_req, 1'b0);
    step();
    drive_nop();
    check("alu wb_data",  wb_data,  16'h1234);
    check("alu wb_wen",   wb_wen,   1'b1);
    check("alu wb_waddr", wb_waddr, 4'd3);

    // Load, ready on 3rd ACCESS cycle
    do_mem("load", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0040, 16'h0000, 16'hBEEF, 3, sc, rc);
    check("load stall cycles", sc, 3);
    check("load req cycles",   rc, 3);
    check("load wb_data",  wb_data,  16'hBEEF);
    check("load wb_wen",   wb_wen,   1'b1);
    check("load wb_waddr", wb_waddr, 4'd5);
    check("load err",      err,      1'b0);

    // Store, ready on 1st ACCESS cycle
    do_mem("store", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0010, 16'hA5A5, 16'h0000, 1, sc, rc);
    check("store stall cycles", sc, 1);
    check("store req cycles",   rc, 1);
    check("store wb_wen", wb_wen, 1'b0);

    // Load that never completes: aborted after 15 ACCESS cycles
    do_mem("tmo", 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 16'h0080, 16'h0000, 16'h0000, 0, sc, rc);
    check("tmo req cycles",   rc, 15);
    check("tmo stall cycles", sc, 15);
    check("tmo wb_wen", wb_wen, 1'b0);
    check("tmo err",    err,    1'b1);
    #1;
    check("tmo idle mem_req", bus.mem_req, 1'b0);
    alu_result = 16'h0777; reg_wen = 1'b1; reg_waddr = 4'd7;
    step();
    drive_nop();
    check("post-tmo wb_data",  wb_data,  16'h0777);
    check("post-tmo wb_wen",   wb_wen,   1'b1);
    check("post-tmo wb_waddr", wb_waddr, 4'd7);
    check("post-tmo err sticky", err,    1'b1);

    // Read and write together: write issued, error raised
    do_reset();
    check("conflict err before", err, 1'b0);
    do_mem("conflict", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0020, 16'h5A5A, 16'h0000, 1, sc, rc);
    check("conflict req cycles", rc, 1);
    check("conflict err", err, 1'b1);

    // Reset asserted on the 2nd ACCESS cycle
    do_reset();
    mem_read = 1'b1; alu_result = 16'h0300; reg_wen = 1'b1; reg_waddr = 4'd9; mem_to_reg = 1'b1;
    step();
    #1;
    check("rstmid 1st access req", bus.mem_req, 1'b1);
    step();
    rst = 1'b0;
    drive_nop();
    #1;
    check("rstmid req masked", bus.mem_req, 1'b0);
    step();
    check("rstmid mem_req", bus.mem_req, 1'b0);
    check("rstmid stall",   stall,       1'b0);
    check("rstmid wb_wen",  wb_wen,      1'b0);
    check("rstmid err",     err,         1'b0);
    rst = 1'b1;
    #1;
    check("rstmid idle after release", bus.mem_req, 1'b0);
    step();
    check("rstmid no writeback", wb_wen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
